// File: rtl/audio_stream_pkg.sv
// audio_stream_pkg: state encodings shared by the flash sample streamer.
// No ports; imported by flash_sample_streamer.
package audio_stream_pkg;

    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_WAIT,
        F_DRAIN
    } fetch_state_t;

    typedef enum logic [2:0] {
        P_IDLE,
        P_LOAD,
        P_WAIT_READY,
        P_SEND,
        P_WAIT_ACCEPT
    } play_state_t;

endpackage

// File: rtl/sample_scale.sv
// sample_scale: divides a signed 16-bit sample by 2^VOL_SHIFT, rounding toward zero.
// Ports: i_sample (signed in), o_sample (signed, attenuated out).
module sample_scale #(
    parameter int VOL_SHIFT = 6
) (
    input  logic signed [15:0] i_sample,
    output logic signed [15:0] o_sample
);

    localparam logic signed [16:0] BIAS = 17'((1 << VOL_SHIFT) - 1);

    logic signed [16:0] w_ext;
    logic signed [16:0] w_biased;

    // Negative inputs get a bias so the arithmetic shift truncates toward zero.
    assign w_ext    = $signed({i_sample[15], i_sample});
    assign w_biased = w_ext + (i_sample[15] ? BIAS : 17'sd0);
    assign o_sample = 16'(w_biased >>> VOL_SHIFT);

endmodule

// File: rtl/flash_sample_streamer.sv
// flash_sample_streamer: streams mono 16-bit samples from flash words into the codec.
// Ports: CLOCK_50/reset, start/stop/loop_en, flash_mem_* Avalon read master,
// write_s/write_ready/writedata_* codec handshake, busy/done status.
module flash_sample_streamer #(
    parameter int ADDR_W    = 23,
    parameter int END_ADDR  = 1048575,
    parameter int VOL_SHIFT = 6
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    input  logic              flash_mem_waitrequest,
    input  logic [31:0]       flash_mem_readdata,
    input  logic              flash_mem_readdatavalid,
    input  logic              write_ready,
    output logic              write_s,
    output logic [15:0]       writedata_left,
    output logic [15:0]       writedata_right,
    output logic              busy,
    output logic              done
);

    import audio_stream_pkg::*;

    localparam logic [ADDR_W-1:0] END_A = ADDR_W'(END_ADDR);
    localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_t      r_fstate, w_fnext;
    play_state_t       r_pstate, w_pnext;
    logic [ADDR_W-1:0] r_fetch_addr;
    logic              r_rd_pend;
    logic [31:0]       r_word_buf;
    logic              r_buf_valid;
    logic              r_buf_last;
    logic [31:0]       r_cur_word;
    logic              r_cur_last;
    logic              r_half;
    logic [15:0]       r_wdata;
    logic              r_done;

    logic              w_start_ok;
    logic              w_rd_done;
    logic              w_at_end;
    logic              w_load;
    logic              w_write_s;
    logic              w_last_acc;
    logic signed [15:0] w_raw;
    logic signed [15:0] w_scaled;

    assign w_start_ok = start && !stop &&
                        (r_pstate == P_IDLE) && (r_fstate == F_IDLE);
    assign w_rd_done  = (r_fstate == F_WAIT) && r_rd_pend &&
                        flash_mem_readdatavalid;
    assign w_at_end   = (r_fetch_addr == END_A);
    assign w_load     = (r_pstate == P_LOAD) && r_buf_valid;
    assign w_last_acc = (r_pstate == P_WAIT_ACCEPT) && !write_ready &&
                        r_half && r_cur_last;
    assign w_raw      = r_half ? r_cur_word[31:16] : r_cur_word[15:0];

    sample_scale #(
        .VOL_SHIFT(VOL_SHIFT)
    ) u_scale (
        .i_sample(w_raw),
        .o_sample(w_scaled)
    );

    always_comb begin
        w_fnext = r_fstate;
        unique case (r_fstate)
            F_IDLE:  if (w_start_ok) w_fnext = F_REQ;
            F_REQ:   if (!flash_mem_waitrequest) w_fnext = F_WAIT;
            F_WAIT: begin
                if (r_rd_pend) begin
                    if (w_rd_done && w_at_end && !loop_en) w_fnext = F_IDLE;
                end else if (!r_buf_valid) begin
                    w_fnext = F_REQ;
                end
            end
            F_DRAIN: if (flash_mem_readdatavalid) w_fnext = F_IDLE;
        endcase
        // A read the slave has taken must still be drained after stop.
        if (stop) begin
            if ((r_fstate == F_REQ && !flash_mem_waitrequest) ||
                (r_fstate == F_WAIT && r_rd_pend && !flash_mem_readdatavalid))
                w_fnext = F_DRAIN;
            else if (r_fstate != F_DRAIN)
                w_fnext = F_IDLE;
        end
    end

    always_comb begin
        w_pnext   = r_pstate;
        w_write_s = 1'b0;
        unique case (r_pstate)
            P_IDLE:       if (w_start_ok) w_pnext = P_LOAD;
            P_LOAD:       if (r_buf_valid) w_pnext = P_WAIT_READY;
            P_WAIT_READY: if (write_ready) w_pnext = P_SEND;
            P_SEND: begin
                w_write_s = 1'b1;
                w_pnext   = P_WAIT_ACCEPT;
            end
            P_WAIT_ACCEPT: begin
                w_write_s = 1'b1;
                if (!write_ready) begin
                    if (!r_half)         w_pnext = P_WAIT_READY;
                    else if (r_cur_last) w_pnext = P_IDLE;
                    else                 w_pnext = P_LOAD;
                end
            end
            default:      w_pnext = P_IDLE;
        endcase
        if (stop) w_pnext = P_IDLE;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_fstate     <= F_IDLE;
            r_pstate     <= P_IDLE;
            r_fetch_addr <= '0;
            r_rd_pend    <= 1'b0;
            r_word_buf   <= '0;
            r_buf_valid  <= 1'b0;
            r_buf_last   <= 1'b0;
            r_cur_word   <= '0;
            r_cur_last   <= 1'b0;
            r_half       <= 1'b0;
            r_wdata      <= '0;
            r_done       <= 1'b0;
        end else begin
            r_fstate <= w_fnext;
            r_pstate <= w_pnext;
            r_done   <= w_last_acc && !stop;

            if (r_fstate == F_REQ && !flash_mem_waitrequest)
                r_rd_pend <= 1'b1;
            else if (flash_mem_readdatavalid)
                r_rd_pend <= 1'b0;

            if (w_start_ok)
                r_fetch_addr <= '0;
            else if (w_rd_done && !stop)
                r_fetch_addr <= w_at_end ? '0 : r_fetch_addr + ONE_A;

            // Fetch can only complete into an empty buffer, so set and clear never collide.
            if (stop || w_start_ok) begin
                r_buf_valid <= 1'b0;
            end else if (w_rd_done) begin
                r_word_buf  <= flash_mem_readdata;
                r_buf_valid <= 1'b1;
                r_buf_last  <= w_at_end && !loop_en;
            end else if (w_load) begin
                r_buf_valid <= 1'b0;
            end

            if (w_load && !stop) begin
                r_cur_word <= r_word_buf;
                r_cur_last <= r_buf_last;
                r_half     <= 1'b0;
            end else if (r_pstate == P_WAIT_ACCEPT && !write_ready &&
                         !r_half && !stop) begin
                r_half <= 1'b1;
            end

            if (r_pstate == P_WAIT_READY && write_ready && !stop)
                r_wdata <= w_scaled;
        end
    end

    assign flash_mem_read    = (r_fstate == F_REQ);
    assign flash_mem_address = r_fetch_addr;
    assign write_s           = w_write_s;
    assign writedata_left    = r_wdata;
    assign writedata_right   = r_wdata;
    assign busy              = (r_pstate != P_IDLE);
    assign done              = r_done;

endmodule

// File: tb/tb_flash_sample_streamer.sv
// tb_flash_sample_streamer: randomized flash/codec models checked against a
// behavioural sample/address model; END_ADDR=2 gives a three-word clip.
module tb_flash_sample_streamer;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        start, stop, loop_en;
    logic        flash_mem_read;
    logic [22:0] flash_mem_address;
    logic        flash_mem_waitrequest;
    logic [31:0] flash_mem_readdata;
    logic        flash_mem_readdatavalid;
    logic        write_ready;
    logic        write_s;
    logic [15:0] writedata_left, writedata_right;
    logic        busy, done;

    flash_sample_streamer #(
        .ADDR_W(23), .END_ADDR(2), .VOL_SHIFT(6)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .start(start), .stop(stop), .loop_en(loop_en),
        .flash_mem_read(flash_mem_read),
        .flash_mem_address(flash_mem_address),
        .flash_mem_waitrequest(flash_mem_waitrequest),
        .flash_mem_readdata(flash_mem_readdata),
        .flash_mem_readdatavalid(flash_mem_readdatavalid),
        .write_ready(write_ready), .write_s(write_s),
        .writedata_left(writedata_left),
        .writedata_right(writedata_right),
        .busy(busy), .done(done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [0:2];
    bit   pass_loop = 1'b0;
    int   rd_cnt = 0, smp_cnt = 0, done_cnt = 0;
    int   rd_log[$];
    int   smp_log[$];

    bit          f_pend = 1'b0;
    int          f_lat = 0;
    logic [22:0] f_addr = '0;
    int          lat_force = -1;
    bit          stall_arm = 1'b0;
    int          st_chk = 0;
    logic [22:0] st_addr = '0;

    int codec_delay = 0;
    bit codec_stick = 1'b0;
    int rdy_wait = 0;
    bit prev_ws = 1'b0, rdy_prev = 1'b1, rdy_prev2 = 1'b1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Read j of a pass targets word j, wrapping over the 3-word clip when looping.
    function automatic int exp_addr(input int j);
        return pass_loop ? (j % 3) : j;
    endfunction

    // Sample i is half (i%2) of word i/2, divided by 64 with truncation toward zero.
    function automatic int exp_sample(input int i);
        logic [31:0] w;
        shortint     s;
        w = mem[(i / 2) % 3];
        s = (i % 2) ? w[31:16] : w[15:0];
        return int'(s) / 64;
    endfunction

    initial begin : flash_model
        flash_mem_waitrequest   = 1'b0;
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = '0;
        forever begin
            @(negedge CLOCK_50);
            flash_mem_readdatavalid = 1'b0;
            if (reset) begin
                f_pend = 1'b0;
                flash_mem_waitrequest = 1'b0;
            end else begin
                if (f_pend) begin
                    if (f_lat == 0) begin
                        flash_mem_readdatavalid = 1'b1;
                        flash_mem_readdata = mem[f_addr % 3];
                        f_pend = 1'b0;
                    end else begin
                        f_lat--;
                    end
                end
                if (st_chk > 0) begin
                    chk("stall_read_held", flash_mem_read, 1);
                    chk("stall_addr_held", flash_mem_address, st_addr);
                    st_chk--;
                    flash_mem_waitrequest = (st_chk > 0);
                end else if (stall_arm && flash_mem_read) begin
                    stall_arm = 1'b0;
                    st_addr = flash_mem_address;
                    st_chk = 5;
                    flash_mem_waitrequest = 1'b1;
                end else begin
                    flash_mem_waitrequest = ($urandom_range(0, 3) == 0);
                end
                if (flash_mem_read && !flash_mem_waitrequest) begin
                    chk("rd_addr", flash_mem_address, exp_addr(rd_cnt));
                    chk("rd_one_outstanding", f_pend, 0);
                    rd_log.push_back(int'(flash_mem_address));
                    rd_cnt++;
                    chk("prefetch_bound", rd_cnt <= smp_cnt / 2 + 2, 1);
                    chk("no_extra_read", pass_loop || rd_cnt <= 3, 1);
                    f_pend = 1'b1;
                    f_addr = flash_mem_address;
                    f_lat = (lat_force >= 0) ? lat_force : $urandom_range(0, 3);
                end
            end
        end
    end

    initial begin : codec_model
        int got;
        write_ready = 1'b1;
        forever begin
            @(negedge CLOCK_50);
            if (reset) begin
                write_ready = 1'b1;
                prev_ws = 1'b0;
                rdy_prev = 1'b1;
                rdy_prev2 = 1'b1;
            end else begin
                if (write_s)
                    chk("lr_equal", writedata_left, writedata_right);
                if (!rdy_prev && !rdy_prev2)
                    chk("ws_low_not_ready", write_s, 0);
                if (write_s && !prev_ws) begin
                    got = int'($signed(writedata_left));
                    chk("sample", got, exp_sample(smp_cnt));
                    chk("no_extra_sample", pass_loop || smp_cnt < 6, 1);
                    smp_log.push_back(got);
                    smp_cnt++;
                    if (!codec_stick) begin
                        write_ready = 1'b0;
                        rdy_wait = (codec_delay >= 2) ? codec_delay
                                                      : $urandom_range(2, 5);
                    end
                end else if (!write_ready && rdy_wait > 0) begin
                    rdy_wait--;
                    if (rdy_wait == 0) write_ready = 1'b1;
                end
                if (done) begin
                    done_cnt++;
                    chk("done_after_last", smp_cnt, 6);
                    chk("done_not_loop", pass_loop, 0);
                    chk("busy_low_at_done", busy, 0);
                end
                prev_ws = write_s;
                rdy_prev2 = rdy_prev;
                rdy_prev = write_ready;
            end
        end
    end

    task automatic start_pass();
        @(negedge CLOCK_50);
        rd_cnt = 0;
        smp_cnt = 0;
        done_cnt = 0;
        rd_log.delete();
        smp_log.delete();
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int k = 0; k < 3000 && done_cnt == 0; k++) @(negedge CLOCK_50);
        chk(nm, done_cnt, 1);
    endtask

    task automatic stop_and_drain();
        @(negedge CLOCK_50);
        stop = 1'b1;
        @(negedge CLOCK_50);
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_ws", write_s, 0);
        for (int k = 0; k < 50 && f_pend; k++) @(negedge CLOCK_50);
        repeat (3) @(negedge CLOCK_50);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int lit[6];
        int rd_at;
        lit = '{-1, 1, -512, 511, 0, -1};
        reset = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        loop_en = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("rst_read", flash_mem_read, 0);
        chk("rst_addr", flash_mem_address, 0);
        chk("rst_ws", write_s, 0);
        chk("rst_data", writedata_left, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge CLOCK_50);
        reset = 1'b0;

        // Basic playback with a 5-cycle waitrequest stall on the first read.
        mem[0] = 32'h0040FFC0;
        mem[1] = 32'h7FFF8000;
        mem[2] = 32'hFFBFFFFF;
        pass_loop = 1'b0;
        loop_en = 1'b0;
        codec_delay = 3;
        stall_arm = 1'b1;
        start_pass();
        wait_done("basic_done_seen");
        repeat (5) @(negedge CLOCK_50);
        chk("basic_done_once", done_cnt, 1);
        chk("basic_busy_fell", busy, 0);
        chk("basic_count", smp_log.size(), 6);
        for (int i = 0; i < 6 && i < smp_log.size(); i++)
            chk("basic_literal", smp_log[i], lit[i]);
        chk("basic_reads", rd_cnt, 3);

        // Loop wrap with random data, then codec backpressure, then stop.
        for (int i = 0; i < 3; i++) mem[i] = $urandom;
        pass_loop = 1'b1;
        loop_en = 1'b1;
        codec_delay = 0;
        start_pass();
        for (int k = 0; k < 3000 && rd_cnt < 5; k++) @(negedge CLOCK_50);
        chk("loop_reads", rd_cnt >= 5, 1);
        if (rd_log.size() >= 5) begin
            chk("loop_a0", rd_log[0], 0);
            chk("loop_a1", rd_log[1], 1);
            chk("loop_a2", rd_log[2], 2);
            chk("loop_a3", rd_log[3], 0);
            chk("loop_a4", rd_log[4], 1);
        end
        codec_delay = 20;
        for (int k = 0; k < 300 && !(rdy_wait >= 15 && !write_ready); k++)
            @(negedge CLOCK_50);
        rd_at = rd_cnt;
        repeat (15) @(negedge CLOCK_50);
        chk("bp_max_one_read", rd_cnt - rd_at <= 1, 1);
        chk("bp_ws_low", write_s, 0);
        codec_delay = 0;
        repeat (60) @(negedge CLOCK_50);
        chk("loop_no_done", done_cnt, 0);
        chk("loop_busy", busy, 1);
        stop_and_drain();

        // Stop while a read is in flight; the late data must be discarded.
        pass_loop = 1'b0;
        loop_en = 1'b0;
        lat_force = 8;
        start_pass();
        for (int k = 0; k < 500 && !(rd_cnt >= 2 && f_pend); k++)
            @(negedge CLOCK_50);
        chk("mid_read_reached", rd_cnt >= 2 && f_pend, 1);
        @(negedge CLOCK_50);
        stop = 1'b1;
        @(negedge CLOCK_50);
        stop = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLOCK_50);
            chk("drain_busy", busy, 0);
            chk("drain_ws", write_s, 0);
        end
        lat_force = -1;
        start_pass();
        wait_done("restart_done");
        if (rd_log.size() > 0) chk("restart_addr0", rd_log[0], 0);
        chk("restart_count", smp_cnt, 6);

        // Asynchronous reset while a sample is being offered.
        codec_stick = 1'b1;
        start_pass();
        for (int k = 0; k < 500 && !write_s; k++) @(negedge CLOCK_50);
        @(posedge CLOCK_50);
        #2;
        chk("pre_reset_ws", write_s, 1);
        reset = 1'b1;
        #1;
        chk("areset_ws", write_s, 0);
        chk("areset_read", flash_mem_read, 0);
        chk("areset_busy", busy, 0);
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        codec_stick = 1'b0;

        // Recovery pass after reset.
        for (int i = 0; i < 3; i++) mem[i] = $urandom;
        start_pass();
        wait_done("recover_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
